// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I fields plus a signed immediate into a 32-bit instruction word,
//   flags immediates that are out of range or misaligned for the opcode's format, and counts handoffs.
// Latency 2 cycles (field register, packed-word register); throughput 1 word/cycle.
// Backpressure: out_ready low freezes stage 2; stage 1 absorbs one more word, then in_ready drops.
// Ports: clk/rst_n; in_valid/in_ready + opcode, rd, rs1, rs2, funct3, funct7, immediate;
//   out_valid/out_ready + instruction, out_error; counters_clear, encoded_count, error_count.
module instruction_encoder #(
    parameter int COUNT_WIDTH       = 16,
    parameter int ERROR_COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [6:0]                   opcode,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [2:0]                   funct3,
    input  logic [6:0]                   funct7,
    input  logic [31:0]                  immediate,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  instruction,
    output logic                         out_error,
    input  logic                         counters_clear,
    output logic [COUNT_WIDTH-1:0]       encoded_count,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count
);
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

    fmt_t               in_fmt;
    logic               in_err;
    logic signed [31:0] imm_s;

    logic               s1_valid;
    fmt_t               s1_fmt;
    logic               s1_err;
    logic [6:0]         s1_opcode;
    logic [4:0]         s1_rd;
    logic [4:0]         s1_rs1;
    logic [4:0]         s1_rs2;
    logic [2:0]         s1_funct3;
    logic [6:0]         s1_funct7;
    logic [31:0]        s1_imm;

    logic [31:0]        packed_word;
    logic               s2_load;
    logic               handoff;

    assign imm_s    = immediate;
    assign s2_load  = !out_valid || out_ready;
    // Depends only on registered state and out_ready, never on in_valid.
    assign in_ready = !s1_valid || s2_load;
    assign handoff  = out_valid && out_ready;

    always_comb begin
        in_fmt = FMT_R;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111: in_fmt = FMT_I;
            7'b0100011:                         in_fmt = FMT_S;
            7'b1100011:                         in_fmt = FMT_B;
            7'b0010111, 7'b0110111:             in_fmt = FMT_U;
            7'b1101111:                         in_fmt = FMT_J;
            default:                            in_fmt = FMT_R;
        endcase
    end

    // B and J offsets are byte offsets whose bit 0 is not encodable, so odd values are errors.
    always_comb begin
        in_err = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: in_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            FMT_B:        in_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || immediate[0];
            FMT_J:        in_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || immediate[0];
            FMT_U:        in_err = (immediate[11:0] != 12'd0);
            default:      in_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_R;
            s1_err    <= 1'b0;
            s1_opcode <= 7'd0;
            s1_rd     <= 5'd0;
            s1_rs1    <= 5'd0;
            s1_rs2    <= 5'd0;
            s1_funct3 <= 3'd0;
            s1_funct7 <= 7'd0;
            s1_imm    <= 32'd0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= in_fmt;
                s1_err    <= in_err;
                s1_opcode <= opcode;
                s1_rd     <= rd;
                s1_rs1    <= rs1;
                s1_rs2    <= rs2;
                s1_funct3 <= funct3;
                s1_funct7 <= funct7;
                s1_imm    <= immediate;
            end
        end
    end

    // Out-of-range immediates are still packed from their truncated bits.
    always_comb begin
        packed_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
        case (s1_fmt)
            FMT_I: packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S: packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B: packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                  s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U: packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J: packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                  s1_rd, s1_opcode};
            default: packed_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            instruction <= 32'd0;
            out_error   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                instruction <= packed_word;
                out_error   <= s1_err;
            end
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            encoded_count <= '0;
            error_count   <= '0;
        end else if (counters_clear) begin
            encoded_count <= '0;
            error_count   <= '0;
        end else if (handoff) begin
            if (encoded_count != {COUNT_WIDTH{1'b1}}) begin
                encoded_count <= encoded_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (out_error && (error_count != {ERROR_COUNT_WIDTH{1'b1}})) begin
                error_count <= error_count + {{(ERROR_COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed and random stimulus for instruction_encoder against a
//   behavioural encoder model and a scoreboard of expected words, with saturating counter model.
// Clock period 10; inputs driven 1 after the rising edge, outputs sampled on the falling edge.
module tb_instruction_encoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        out_error;
    logic        counters_clear;
    logic [15:0] encoded_count;
    logic [7:0]  error_count;

    always #5 clk = ~clk;

    instruction_encoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .opcode         (opcode),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .funct3         (funct3),
        .funct7         (funct7),
        .immediate      (immediate),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction    (instruction),
        .out_error      (out_error),
        .counters_clear (counters_clear),
        .encoded_count  (encoded_count),
        .error_count    (error_count)
    );

    typedef struct {
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] obs_word[$];
    logic        obs_err[$];
    int          total = 0;
    int          bad = 0;
    int          m_enc = 0;
    int          m_err = 0;
    int          acc_cnt = 0;
    int          ho_cnt = 0;

    int bnd [14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                     -1048577, -1048576, 1048574, 1048575, 1048576};
    logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h33};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference encoder: format and range rules evaluated with integer arithmetic and shifts.
    function automatic exp_t ref_enc(bit [31:0] op, bit [31:0] rdv, bit [31:0] r1, bit [31:0] r2,
                                     bit [31:0] f3, bit [31:0] f7, bit [31:0] imm);
        exp_t e;
        int   si;
        bit [31:0] common;
        si     = $signed(imm);
        common = (r1 << 15) | (f3 << 12) | op;
        e.err  = 1'b0;
        case (op)
            32'h03, 32'h13, 32'h67: begin
                e.word = ((imm & 32'hFFF) << 20) | common | (rdv << 7);
                e.err  = (si < -2048) || (si > 2047);
            end
            32'h23: begin
                e.word = (((imm >> 5) & 32'h7F) << 25) | (r2 << 20) | common | ((imm & 32'h1F) << 7);
                e.err  = (si < -2048) || (si > 2047);
            end
            32'h63: begin
                e.word = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r2 << 20) |
                         common | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
                e.err  = (si < -4096) || (si > 4094) || ((si % 2) != 0);
            end
            32'h17, 32'h37: begin
                e.word = (imm & 32'hFFFFF000) | (rdv << 7) | op;
                e.err  = (imm % 4096) != 0;
            end
            32'h6F: begin
                e.word = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                         (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rdv << 7) | op;
                e.err  = (si < -1048576) || (si > 1048574) || ((si % 2) != 0);
            end
            default: begin
                e.word = (f7 << 25) | (r2 << 20) | common | (rdv << 7);
            end
        endcase
        return e;
    endfunction

    // One clock: score the handshakes seen before the edge, then check counters after it.
    task automatic tick();
        exp_t e;
        bit   ho;
        bit   acc;
        @(negedge clk);
        ho  = out_valid && out_ready;
        acc = in_valid && in_ready;
        chk("in_ready", 32'(in_ready), 32'((sb.size() < 2) || out_ready));
        if (ho) begin
            obs_word.push_back(instruction);
            obs_err.push_back(out_error);
            ho_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL out_without_word observed=0x%08h expected=none", instruction);
            end else begin
                e = sb.pop_front();
                chk("word", instruction, e.word);
                chk("err", 32'(out_error), 32'(e.err));
                if (!counters_clear) begin
                    if (m_enc < 65535) m_enc++;
                    if (e.err && m_err < 255) m_err++;
                end
            end
        end
        if (counters_clear) begin
            m_enc = 0;
            m_err = 0;
        end
        if (acc) begin
            sb.push_back(ref_enc(32'(opcode), 32'(rd), 32'(rs1), 32'(rs2), 32'(funct3),
                                 32'(funct7), immediate));
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        chk("encoded_count", 32'(encoded_count), 32'(m_enc));
        chk("error_count", 32'(error_count), 32'(m_err));
    endtask

    task automatic drive(input bit [6:0] op, input bit [4:0] r_d, input bit [4:0] r_s1,
                         input bit [4:0] r_s2, input bit [2:0] f3, input bit [6:0] f7,
                         input bit [31:0] imm);
        opcode    = op;
        rd        = r_d;
        rs1       = r_s1;
        rs2       = r_s2;
        funct3    = f3;
        funct7    = f7;
        immediate = imm;
        in_valid  = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    function automatic bit [31:0] rand_imm();
        case ($urandom_range(0, 5))
            0: return 32'($signed($urandom_range(0, 63)) - 32);
            1: return 32'(bnd[$urandom_range(0, 13)]);
            2: return $urandom();
            3: return $urandom() & 32'hFFFFF000;
            4: return 32'($signed($urandom_range(0, 8191)) - 4096);
            default: return 32'($signed($urandom_range(0, 2097151)) - 1048576);
        endcase
    endfunction

    initial begin
        int h;
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        counters_clear = 1'b0;
        drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid       = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_out_error", 32'(out_error), 32'd0);
        chk("rst_encoded_count", 32'(encoded_count), 32'd0);
        chk("rst_error_count", 32'(error_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // addi x1,x0,5 with 2-cycle latency
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        chk("lat1_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat2_out_valid", 32'(out_valid), 32'd1);
        chk("addi_word", instruction, 32'h00500093);
        chk("addi_err", 32'(out_error), 32'd0);

        // Known encodings and error cases, back-to-back
        drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);          tick();
        drive(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);   tick();
        drive(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);       tick();
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);       tick();
        drive(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);          tick();
        drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);   tick();
        drain();
        chk("vec_count", 32'(obs_word.size()), 32'd7);
        chk("sw_word", obs_word[1], 32'h0020A423);
        chk("beq_word", obs_word[2], 32'hFE000EE3);
        chk("jal_word", obs_word[3], 32'h001000EF);
        chk("jal_err", 32'(obs_err[3]), 32'd0);
        chk("addi2048_word", obs_word[4], 32'h80000093);
        chk("addi2048_err", 32'(obs_err[4]), 32'd1);
        chk("beq3_err", 32'(obs_err[5]), 32'd1);
        chk("lui_err", 32'(obs_err[6]), 32'd1);
        chk("lui_word", obs_word[6], 32'h123452B7);
        chk("vec_encoded_count", 32'(encoded_count), 32'd7);
        chk("vec_error_count", 32'(error_count), 32'd3);

        // Stall: out_ready low for 4 cycles while offering 3 words
        obs_word.delete();
        obs_err.delete();
        acc_cnt   = 0;
        out_ready = 1'b0;
        drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10); tick();
        drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd20); tick();
        chk("stall_first_word", instruction, 32'h00A00113);
        drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd30); tick();
        tick();
        chk("stall_accepted", 32'(acc_cnt), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_held_word", instruction, 32'h00A00113);
        out_ready = 1'b1;
        h = ho_cnt;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("release_b2b", 32'(ho_cnt - h), 32'd3);
        chk("release_0", obs_word[0], 32'h00A00113);
        chk("release_1", obs_word[1], 32'h01400113);
        chk("release_2", obs_word[2], 32'h01E00113);
        drain();

        // Random traffic with random backpressure and occasional clears
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 8)],
                  5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
                  7'($urandom()), rand_imm());
            in_valid       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            counters_clear = ($urandom_range(0, 49) == 0);
            tick();
        end
        counters_clear = 1'b0;
        drain();

        // Saturation of error_count
        counters_clear = 1'b1;
        in_valid       = 1'b0;
        tick();
        counters_clear = 1'b0;
        chk("clr_encoded_count", 32'(encoded_count), 32'd0);
        for (int i = 0; i < 300; i++) begin
            drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
            tick();
        end
        drain();
        chk("sat_error_count", 32'(error_count), 32'd255);
        chk("sat_encoded_count", 32'(encoded_count), 32'd300);
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        counters_clear = 1'b1;
        h = ho_cnt;
        tick();
        counters_clear = 1'b0;
        chk("clr_with_handoff", 32'(ho_cnt - h), 32'd1);
        chk("clr_prio_encoded", 32'(encoded_count), 32'd0);
        chk("clr_prio_error", 32'(error_count), 32'd0);

        // Reset with both stages full
        drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        tick();
        in_valid = 1'b0;
        drain();
        out_ready = 1'b0;
        drive(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); tick();
        drive(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2); tick();
        in_valid = 1'b0;
        tick();
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_instruction", instruction, 32'd0);
        chk("arst_encoded_count", 32'(encoded_count), 32'd0);
        sb.delete();
        m_enc = 0;
        m_err = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        tick();
        in_valid = 1'b0;
        chk("post_rst_lat1", 32'(out_valid), 32'd0);
        tick();
        chk("post_rst_lat2", 32'(out_valid), 32'd1);
        chk("post_rst_word", instruction, 32'h00700093);
        chk("post_rst_count", 32'(encoded_count), 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
